// File: rtl/serial_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen_pkg
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and state-vector width, used by the top level and visible to benches.
// -----------------------------------------------------------------------------
package serial_pattern_gen_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is unused; the next-state logic maps it back to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_pattern_gen_piso.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen_piso
// Parallel-load, shift-left register. The MSB is the serial output; zeros are
// shifted in, so after WIDTH shifts the register is empty and the output is 0.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous active-high reset (clears the register)
//   load   in   1      load din (has priority over shift)
//   shift  in   1      shift left by one, zero fill
//   din    in   WIDTH  parallel load word
//   msb    out  1      current MSB (registered)
// -----------------------------------------------------------------------------
module serial_pattern_gen_piso #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen
// Serial pattern transmitter: captures a W-bit pattern and a repeat count on an
// accepted start, then shifts the pattern out MSB-first, one bit per clock,
// repeating it with GAP_CYCLES idle cycles between repetitions.
// Optional feature macro: SERIAL_PATTERN_GEN_PARITY_EN appends one even-parity
// bit (^pattern) to every repetition; done then moves to the parity bit.
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous active-high reset, priority over all
//   start      in   1        request, sampled only in IDLE
//   pattern    in   W        word to send, captured on accepted start
//   reps       in   REP_W    repetition count, captured on start (0 -> 1)
//   out        out  1        serial data bit (registered)
//   out_valid  out  1        high while out carries a pattern/parity bit
//   busy       out  1        high in SEND and GAP
//   done       out  1        pulse with the final bit of the final repetition
//   present    out  2        current state encoding
//   next       out  2        combinational next-state encoding
// -----------------------------------------------------------------------------
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int W          = 5,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W-1:0]       pattern,
    input  logic [REP_W-1:0]   reps,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] present,
    output logic [STATE_W-1:0] next
);

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    localparam int LEN = W + 1;
`else
    localparam int LEN = W;
`endif
    localparam int CNT_W = $clog2(LEN + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;     // bits already sent in this repetition
    logic [REP_W-1:0] reps_left;   // repetitions still to send, incl. current
    logic [GAP_W-1:0] gap_cnt;
    logic [LEN-1:0]   word_in;     // repetition word built from the inputs
    logic [LEN-1:0]   word_q;      // captured word, reloaded every repetition
    logic             accept;
    logic             last_bit;
    logic             last_rep;
    logic             gap_end;
    logic             reload;
    logic             piso_load;
    logic             piso_msb;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    assign word_in = {pattern, ^pattern};
`else
    assign word_in = pattern;
`endif

    assign accept   = (state == IDLE) && start;
    assign last_bit = (bit_cnt == CNT_W'(LEN - 1));
    assign last_rep = (reps_left == REP_W'(1));
    assign gap_end  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Pattern is reloaded at the end of a gap, or straight after the last bit
    // when repetitions run back-to-back.
    assign reload = ((state == GAP) && gap_end) ||
                    ((state == SEND) && last_bit && !last_rep && (GAP_CYCLES == 0));
    assign piso_load = accept || reload;

    // The register empties itself by shifting, so out is 0 in IDLE/GAP
    // without any output gating.
    serial_pattern_gen_piso #(.WIDTH(LEN)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (piso_load),
        .shift (state == SEND),
        .din   (accept ? word_in : word_q),
        .msb   (piso_msb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: a default assignment first keeps every path assigned, so no
    // latch is inferred from this combinational block.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: state_next = start ? SEND : IDLE;
            SEND: begin
                if (!last_bit)             state_next = SEND;
                else if (last_rep)         state_next = IDLE;
                else if (GAP_CYCLES == 0)  state_next = SEND;
                else                       state_next = GAP;
            end
            GAP:     state_next = gap_end ? SEND : GAP;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        out       = piso_msb;
        out_valid = (state == SEND);
        busy      = (state != IDLE);
        done      = (state == SEND) && last_bit && last_rep;
        present   = state;
        next      = state_next;
    end

    // Counters and captured word; start while busy never reaches the IDLE arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            word_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        word_q    <= word_in;
                        reps_left <= (reps == '0) ? REP_W'(1) : reps;
                        bit_cnt   <= '0;
                    end
                end
                SEND: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        // Decrement only while more remain: max count never wraps.
                        if (!last_rep) reps_left <= reps_left - REP_W'(1);
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                GAP:     gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_gen
// Self-checking bench for serial_pattern_gen (W=5, REP_W=4, GAP_CYCLES=2).
// Each accepted start pushes the expected per-cycle output vectors into a
// queue; a monitor pops and compares one vector per cycle on the falling edge.
// Honors SERIAL_PATTERN_GEN_PARITY_EN to expect the trailing parity bit.
// -----------------------------------------------------------------------------
module tb_serial_pattern_gen;

    localparam int W     = 5;
    localparam int REP_W = 4;
    localparam int GAP   = 2;

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       out;
        logic       done;
        logic [1:0] present;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     pattern = '0;
    logic [REP_W-1:0] reps = '0;
    logic             out, out_valid, busy, done;
    logic [1:0]       present, next;

    int   errors = 0;
    int   checks = 0;
    int   n_pop  = 0;
    exp_t exp_q[$];

    serial_pattern_gen #(.W(W), .REP_W(REP_W), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .reps      (reps),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .present   (present),
        .next      (next)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected stream for one transfer, plus the trailing IDLE cycle.
    task automatic push_stream(input logic [W-1:0] pat, input int r);
        int   eff;
        logic [W:0] word;
        int   len;
        eff = (r == 0) ? 1 : r;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        word = {pat, ^pat};
        len  = W + 1;
`else
        word = {1'b0, pat};
        len  = W;
`endif
        for (int k = 0; k < eff; k++) begin
            for (int b = len - 1; b >= 0; b--)
                exp_q.push_back('{1'b1, 1'b1, word[b], (k == eff - 1) && (b == 0), 2'b01});
            if (k < eff - 1)
                for (int g = 0; g < GAP; g++)
                    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    endtask

    // Monitor: one expected vector per cycle while the queue holds any.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("stream[%0d]", n_pop),
                      {26'd0, busy, out_valid, out, done, present}, {26'd0, e});
                n_pop++;
            end
        end
    end

    // Drive start for one cycle; the accept edge is the posedge after it.
    task automatic launch(input logic [W-1:0] pat, input int r);
        @(posedge clk);
        #1;
        start   = 1'b1;
        pattern = pat;
        reps    = REP_W'(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        push_stream(pat, r);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out",     out,       0);
        check("rst_valid",   out_valid, 0);
        check("rst_busy",    busy,      0);
        check("rst_done",    done,      0);
        check("rst_present", present,   2'b00);
        check("rst_next",    next,      2'b00);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single 11011, also checking the combinational next-state
        @(posedge clk);
        #1;
        start = 1'b1; pattern = 5'b11011; reps = 4'd1;
        #1;
        check("next_on_start",    next,    2'b01);
        check("present_on_start", present, 2'b00);
        @(posedge clk);
        #1 start = 1'b0;
        push_stream(5'b11011, 1);
        wait_drain("single");

        // Three repetitions with gaps
        launch(5'b11011, 3);
        wait_drain("reps3");

        // reps=0 behaves like reps=1
        launch(5'b10011, 0);
        wait_drain("reps0");

        // start with pattern 00000 at t3 is ignored
        launch(5'b11011, 1);
        repeat (2) @(posedge clk);
        #1; start = 1'b1; pattern = 5'b00000; reps = 4'd7;
        @(posedge clk);
        #1; start = 1'b0;
        wait_drain("ignored_start");

        // start held high: ignored in done cycle, accepted in the IDLE cycle;
        // inputs changed mid-transfer only affect the second transfer.
        @(posedge clk);
        #1; start = 1'b1; pattern = 5'b11011; reps = 4'd1;
        @(posedge clk);
        #1;
        push_stream(5'b11011, 1);
        push_stream(5'b10110, 2);
        pattern = 5'b10110; reps = 4'd2;
        repeat (6) @(posedge clk);
        #1 start = 1'b0;
        wait_drain("held_start");

        // Maximum repetition count, no counter wrap
        launch(5'b10010, 15);
        wait_drain("reps_max");

        // Odd-parity pattern
        launch(5'b11010, 2);
        wait_drain("odd_ones");

        // Reset asserted during bit 3
        @(posedge clk);
        #1; start = 1'b1; pattern = 5'b11011; reps = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("rst_mid_b1", {out, done}, 2'b10);
        @(negedge clk);
        check("rst_mid_b2", {out, done}, 2'b10);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_b3", {out, done}, 2'b00);
        @(posedge clk);
        #1;
        check("abort_out",     out,       0);
        check("abort_valid",   out_valid, 0);
        check("abort_busy",    busy,      0);
        check("abort_done",    done,      0);
        check("abort_present", present,   2'b00);
        reset = 1'b0;
        @(negedge clk);
        check("after_abort", {busy, out_valid, done}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
